// File: rtl/conv_window_mac_ctrl.sv
// K x K x C_IN convolution window controller: walks image/weight RAM addresses
// from two start addresses and multiply-accumulates the returned words into one pixel.
module conv_window_mac_ctrl #(
  parameter int DATA_W     = 8,
  parameter int IMG_ADDR_W = 10,
  parameter int W_ADDR_W   = 8,
  parameter int ACC_W      = 24,
  parameter int K          = 3,
  parameter int C_IN       = 1,
  parameter int IMG_WIDTH  = 32,
  parameter int CH_STRIDE  = 1024,
  parameter int RD_LAT     = 1,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IMG_ADDR_W-1:0] s_img_addr,
  input  logic [W_ADDR_W-1:0]   s_w_addr,
  input  logic [DATA_W-1:0]     img_data,
  input  logic [DATA_W-1:0]     w_data,
  output logic [IMG_ADDR_W-1:0] img_addr,
  output logic [W_ADDR_W-1:0]   w_addr,
  output logic                  d_ena,
  output logic [ACC_W-1:0]      calc_data,
  output logic                  done,
  output logic                  data_in_done,
  output logic                  busy
);

  localparam int N     = C_IN * K * K;
  localparam int TAP_W = $clog2(N + 1);
  localparam int KC_W  = (K > 1) ? $clog2(K) : 1;

  localparam logic [KC_W-1:0]       K_LAST     = KC_W'(K - 1);
  localparam logic [TAP_W-1:0]      TAP_LAST   = TAP_W'(N - 1);
  localparam logic [TAP_W-1:0]      TAP_PENULT = TAP_W'(N - 2);
  localparam logic [IMG_ADDR_W-1:0] ROW_STEP   = IMG_ADDR_W'(IMG_WIDTH);
  localparam logic [IMG_ADDR_W-1:0] CH_STEP    = IMG_ADDR_W'(CH_STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic                  w_accept;
  logic                  w_lastTap;
  logic                  w_pipeEmptyNext;
  logic [RD_LAT-1:0]     r_vld;
  logic [RD_LAT-1:0]     w_vldNext;

  logic [IMG_ADDR_W-1:0] r_rowBase;
  logic [IMG_ADDR_W-1:0] r_chBase;
  logic [KC_W-1:0]       r_col;
  logic [KC_W-1:0]       r_row;
  logic [TAP_W-1:0]      r_tap;

  logic [ACC_W-1:0]             r_acc;
  logic [ACC_W-1:0]             w_accNext;
  logic [ACC_W-1:0]             w_prodExt;
  logic signed [2*DATA_W-1:0]   w_prodS;
  logic [2*DATA_W-1:0]          w_prodU;

  assign w_lastTap = (r_tap == TAP_LAST);

  // Valid pipe mirrors the RAM read latency; DRAIN ends once it will be empty.
  always_comb begin
    w_vldNext    = '0;
    w_vldNext[0] = d_ena;
    for (int i = 1; i < RD_LAT; i++) begin
      w_vldNext[i] = r_vld[i-1];
    end
    w_pipeEmptyNext = (w_vldNext == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_lastTap) begin
          w_stateNext = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pipeEmptyNext) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Operands are widened before multiplying so the product is exact in 2*DATA_W bits.
  always_comb begin
    w_prodS = $signed({{DATA_W{img_data[DATA_W-1]}}, img_data}) *
              $signed({{DATA_W{w_data[DATA_W-1]}}, w_data});
    w_prodU = {{DATA_W{1'b0}}, img_data} * {{DATA_W{1'b0}}, w_data};
    if (SIGNED != 0) begin
      w_prodExt = ACC_W'(w_prodS);
    end else begin
      w_prodExt = ACC_W'(w_prodU);
    end
    w_accNext = r_vld[RD_LAT-1] ? (r_acc + w_prodExt) : r_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_addr     <= '0;
      w_addr       <= '0;
      d_ena        <= 1'b0;
      data_in_done <= 1'b0;
      calc_data    <= '0;
      r_rowBase    <= '0;
      r_chBase     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_tap        <= '0;
      r_acc        <= '0;
      r_vld        <= '0;
    end else begin
      r_vld        <= w_vldNext;
      data_in_done <= 1'b0;
      r_acc        <= w_accNext;
      if (w_accept) begin
        img_addr     <= s_img_addr;
        r_rowBase    <= s_img_addr;
        r_chBase     <= s_img_addr;
        w_addr       <= s_w_addr;
        r_col        <= '0;
        r_row        <= '0;
        r_tap        <= '0;
        d_ena        <= 1'b1;
        data_in_done <= (N == 1);
        r_acc        <= '0;
      end else if (r_state == S_FETCH) begin
        if (w_lastTap) begin
          d_ena <= 1'b0;
        end else begin
          r_tap        <= r_tap + TAP_W'(1);
          w_addr       <= w_addr + W_ADDR_W'(1);
          data_in_done <= (r_tap == TAP_PENULT);
          // Row and channel bases advance by addition, so no multiplier is needed.
          if (r_col != K_LAST) begin
            r_col    <= r_col + KC_W'(1);
            img_addr <= img_addr + IMG_ADDR_W'(1);
          end else if (r_row != K_LAST) begin
            r_col     <= '0;
            r_row     <= r_row + KC_W'(1);
            r_rowBase <= r_rowBase + ROW_STEP;
            img_addr  <= r_rowBase + ROW_STEP;
          end else begin
            r_col     <= '0;
            r_row     <= '0;
            r_chBase  <= r_chBase + CH_STEP;
            r_rowBase <= r_chBase + CH_STEP;
            img_addr  <= r_chBase + CH_STEP;
          end
        end
      end
      if ((r_state == S_DRAIN) && w_pipeEmptyNext) begin
        calc_data <= w_accNext;
      end
    end
  end

endmodule
